coherent_cache_ctrl: RTL
========================

COHERENT_CACHE_CTRL -- requirements
Module: coherent_cache_ctrl

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2, number of core ports (legal 1..8).
REQ-002 SHALL have parameter ADDR_W, default 12, word-address width.
REQ-003 SHALL have parameter INDEX_W, default 8, cache index width (lines per core = 2^INDEX_W, one word per line).
REQ-004 SHALL have parameter DATA_W, default 32, data word width.
REQ-005 SHALL have port clk  in  1  the single clock; all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_valid  in  NUM_CORES  per-core request, held until matching resp_done.
REQ-008 SHALL have port req_we  in  NUM_CORES  per-core request type: 1 write, 0 read.
REQ-009 SHALL have port req_addr  in  NUM_CORES*ADDR_W  per-core word address, core i at bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port req_wdata  in  NUM_CORES*DATA_W  per-core write data, same packing.
REQ-011 SHALL have port resp_done  out  NUM_CORES  one-cycle completion pulse per core.
REQ-012 SHALL have port resp_rdata  out  NUM_CORES*DATA_W  read data, valid only with resp_done[i] on a read.
REQ-013 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W  shared main-memory request, held until mem_ack.
REQ-014 SHALL have ports mem_ack in 1, mem_rdata in DATA_W  memory completion, any latency >=1 cycle; mem_rdata valid with mem_ack on reads.

Function
REQ-015 SHALL split address as index = addr[INDEX_W-1:0], tag = addr[ADDR_W-1:INDEX_W]; per core store tag, valid bit, data word per line.
REQ-016 SHALL serve read hit (valid and tag match in own cache) with resp_done[i] and cached data the cycle after req_valid[i] is sampled; no memory access; hits of all cores serviced in parallel.
REQ-017 SHALL route read misses and all writes (write-through, write-allocate) through one shared memory transaction at a time.
REQ-018 SHALL use FSM IDLE -> MEM (grant, mem_req=1) -> DONE (on mem_ack) -> IDLE; DONE lasts exactly one cycle.
REQ-019 SHALL arbitrate pending miss/write requests round-robin in IDLE; priority pointer starts at core 0 after reset, moves to granted+1 (mod NUM_CORES) on each grant.
REQ-020 SHALL register granted core's address, type, write data at grant; mem_* outputs stable through MEM.
REQ-021 On read-miss mem_ack SHALL write mem_rdata, tag, valid=1 into requester line; in DONE pulse resp_done with resp_rdata = that data.
REQ-022 On write mem_ack SHALL write req_wdata, tag, valid=1 into writer line and clear valid in every other core whose same-index line holds matching tag; non-matching tags untouched; resp_done in DONE.
REQ-023 SHALL let read hits of other cores proceed during MEM; a hit sampled before the write's mem_ack returns old data, after it sees invalidation (miss).
REQ-024 SHALL ignore req_valid[i] in the cycle resp_done[i] is high (one-cycle turnaround; no double service).
REQ-025 SHALL never assert resp_done for a core without a request, nor more than once per request.
REQ-026 SHALL ignore mem_ack outside MEM.

Reset
REQ-027 On rst=1 SHALL clear all valid bits of all cores in that cycle, force FSM to IDLE, pointer to core 0, resp_done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, resp_rdata=0.
REQ-028 Reset during MEM SHALL abandon the transaction with no resp_done; held requests re-arbitrate after rst falls.

Verification
REQ-029 Cold read: core0 reads 0x123, memory returns 0xDEADBEEF after 3 cycles -> one mem_req read at 0x123, resp_done[0] with 0xDEADBEEF the cycle after mem_ack; repeat read -> hit, resp_done 1 cycle later, no mem_req.
REQ-030 Invalidation: core0 and core1 both cache 0x045; core1 writes 0xCAFE0001 -> mem write 0x045, core0 next read misses and fetches from memory; core1 read hits 0xCAFE0001.
REQ-031 Tag mismatch: core0 caches 0x445, core1 writes 0x045 (same index) -> core0 line 0x445 stays valid, re-read hits.
REQ-032 Contention: NUM_CORES=4, all cores miss same cycle -> grants 0,1,2,3 in order; then cores 2,3 miss again -> grant 2, then 3; one mem_req at a time.
REQ-033 Parallel hit: core1 hit while core0 in MEM -> resp_done[1] one cycle after request, mem_* unchanged.
REQ-034 Reset mid-MEM: rst pulsed while mem_req=1 -> mem_req 0 next cycle, no resp_done, previously cached addresses all miss.

Source files
------------

// File: rtl/coherent_cache_ctrl.sv
// Per-core direct-mapped write-through caches sharing one main-memory port.
// Read hits are served in parallel; misses and writes go round-robin through one memory transaction at a time.
module coherent_cache_ctrl #(
   parameter int NUM_CORES = 2,
   parameter int ADDR_W    = 12,
   parameter int INDEX_W   = 8,
   parameter int DATA_W    = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CORES-1:0]          req_valid,
   input  logic [NUM_CORES-1:0]          req_we,
   input  logic [NUM_CORES*ADDR_W-1:0]   req_addr,
   input  logic [NUM_CORES*DATA_W-1:0]   req_wdata,
   output logic [NUM_CORES-1:0]          resp_done,
   output logic [NUM_CORES*DATA_W-1:0]   resp_rdata,
   output logic                          mem_req,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic                          mem_ack,
   input  logic [DATA_W-1:0]             mem_rdata
);
   localparam int LINES = 1 << INDEX_W;
   localparam int TAG_W = ADDR_W - INDEX_W;
   localparam int CID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_DONE} state_t;
   state_t state_q, state_d;

   logic              valid_q [NUM_CORES][LINES];
   logic              valid_d [NUM_CORES][LINES];
   logic [TAG_W-1:0]  tag_q   [NUM_CORES][LINES];
   logic [TAG_W-1:0]  tag_d   [NUM_CORES][LINES];
   logic [DATA_W-1:0] data_q  [NUM_CORES][LINES];
   logic [DATA_W-1:0] data_d  [NUM_CORES][LINES];

   logic [CID_W-1:0]            grant_q, grant_d, ptr_q, ptr_d, arb_sel;
   logic                        mem_we_q, mem_we_d, arb_found;
   logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]           mem_wdata_q, mem_wdata_d;
   logic [NUM_CORES-1:0]        resp_done_q, resp_done_d, hit, pending;
   logic [NUM_CORES*DATA_W-1:0] resp_rdata_q, resp_rdata_d;
   logic [INDEX_W-1:0]          core_idx [NUM_CORES];
   logic [TAG_W-1:0]            core_tag [NUM_CORES];
   logic [INDEX_W-1:0]          mem_idx;
   logic [TAG_W-1:0]            mem_tag;
   int                          cand;

   assign mem_idx = mem_addr_q[INDEX_W-1:0];
   assign mem_tag = mem_addr_q[ADDR_W-1:INDEX_W];

   // A core is excluded while its own turnaround pulse is high or while it owns the memory port.
   always_comb begin
      for (int i = 0; i < NUM_CORES; i++) begin
         core_idx[i] = req_addr[i*ADDR_W +: INDEX_W];
         core_tag[i] = req_addr[i*ADDR_W+INDEX_W +: TAG_W];
         pending[i]  = req_valid[i] & ~resp_done_q[i] &
                       ~((state_q != ST_IDLE) && (grant_q == CID_W'(i)));
         hit[i]      = pending[i] & ~req_we[i] & valid_q[i][core_idx[i]] &
                       (tag_q[i][core_idx[i]] == core_tag[i]);
         pending[i]  = pending[i] & ~hit[i];
      end
   end

   always_comb begin
      arb_found = 1'b0;
      arb_sel   = '0;
      cand      = 0;
      for (int k = 0; k < NUM_CORES; k++) begin
         cand = (int'(ptr_q) + k) % NUM_CORES;
         if (!arb_found && pending[cand]) begin
            arb_found = 1'b1;
            arb_sel   = CID_W'(cand);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (arb_found) state_d = ST_MEM;
         ST_MEM:  if (mem_ack)   state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_req    = (state_q == ST_MEM);
      mem_we     = mem_we_q;
      mem_addr   = mem_addr_q;
      mem_wdata  = mem_wdata_q;
      resp_done  = resp_done_q;
      resp_rdata = resp_rdata_q;
   end

   always_comb begin
      grant_d      = grant_q;
      ptr_d        = ptr_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      valid_d      = valid_q;
      tag_d        = tag_q;
      data_d       = data_q;
      resp_done_d  = '0;
      resp_rdata_d = resp_rdata_q;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (hit[i]) begin
            resp_done_d[i] = 1'b1;
            resp_rdata_d[i*DATA_W +: DATA_W] = data_q[i][core_idx[i]];
         end
      end
      if (state_q == ST_IDLE && arb_found) begin
         grant_d     = arb_sel;
         ptr_d       = CID_W'((int'(arb_sel) + 1) % NUM_CORES);
         mem_we_d    = req_we[arb_sel];
         mem_addr_d  = req_addr[arb_sel*ADDR_W +: ADDR_W];
         mem_wdata_d = req_wdata[arb_sel*DATA_W +: DATA_W];
      end
      // Fill the requester's line; a write also invalidates matching copies held by other cores.
      if (state_q == ST_MEM && mem_ack) begin
         valid_d[grant_q][mem_idx] = 1'b1;
         tag_d[grant_q][mem_idx]   = mem_tag;
         data_d[grant_q][mem_idx]  = mem_we_q ? mem_wdata_q : mem_rdata;
         resp_done_d[grant_q]      = 1'b1;
         if (!mem_we_q) resp_rdata_d[grant_q*DATA_W +: DATA_W] = mem_rdata;
         if (mem_we_q) begin
            for (int j = 0; j < NUM_CORES; j++) begin
               if (CID_W'(j) != grant_q && tag_q[j][mem_idx] == mem_tag)
                  valid_d[j][mem_idx] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= '{default: '0};
         grant_q      <= '0;
         ptr_q        <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         resp_done_q  <= '0;
         resp_rdata_q <= '0;
      end else begin
         valid_q      <= valid_d;
         grant_q      <= grant_d;
         ptr_q        <= ptr_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_done_q  <= resp_done_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end
endmodule
